md_ctrl: RTL and testbench

- Sequencer and hazard controller for the multi-cycle multiply/divide unit in the pipelined MIPS core.
- Takes the E-stage HI/LO operation, issues a start pulse with a decoded op to the MD datapath and tracks its latency with a down-counter.
- Gates starts and mthi/mtlo writes on M-stage exception/eret (flush).
- Generates the D-stage stall for HI/LO users while the unit is starting or busy.

---
 rtl/md_pkg.sv | 46 ++++
 rtl/md_ctrl_if.sv | 31 +++
 rtl/md_lat_cnt.sv | 31 +++
 rtl/md_ctrl.sv | 120 ++++++++++++
 tb/tb_md_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer and the MD datapath:
// E-stage op encodings, datapath start_op encodings, FSM state type and
// default latencies.
package md_pkg;

    localparam int unsigned MD_OP_W        = 3;
    localparam int unsigned MD_START_OP_W  = 2;
    localparam int unsigned MD_CNT_W       = 4;
    localparam int unsigned MD_MULT_CYCLES = 5;
    localparam int unsigned MD_DIV_CYCLES  = 10;

    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_t;

    typedef enum logic [MD_START_OP_W-1:0] {
        SOP_MULT  = 2'd0,
        SOP_MULTU = 2'd1,
        SOP_DIV   = 2'd2,
        SOP_DIVU  = 2'd3
    } md_start_op_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN_MUL = 2'd1,
        ST_RUN_DIV = 2'd2
    } md_state_t;

    // Ops that launch the multi-cycle datapath
    function automatic logic is_md_op(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Ops that write HI/LO directly
    function automatic logic is_mt_op(input md_op_t op);
        return (op == MD_MTHI) || (op == MD_MTLO);
    endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// Pipeline <-> MD sequencer signal bundle.
//   master: pipeline side (drives E-stage op, flush, D-stage HI/LO use)
//   slave : md_ctrl side (drives start/start_op, mt_we/mt_hi, busy, done,
//           stall, proto_err)
interface md_ctrl_if;
    import md_pkg::*;

    logic                     e_valid;
    logic [MD_OP_W-1:0]       e_md_op;
    logic                     flush;
    logic                     d_hilo_use;
    logic                     start;
    logic [MD_START_OP_W-1:0] start_op;
    logic                     mt_we;
    logic                     mt_hi;
    logic                     busy;
    logic                     done;
    logic                     stall;
    logic                     proto_err;

    modport master (
        output e_valid, e_md_op, flush, d_hilo_use,
        input  start, start_op, mt_we, mt_hi, busy, done, stall, proto_err
    );

    modport slave (
        input  e_valid, e_md_op, flush, d_hilo_use,
        output start, start_op, mt_we, mt_hi, busy, done, stall, proto_err
    );

endinterface

// File: rtl/md_lat_cnt.sv
// Loadable latency down-counter with last-cycle detect.
//   clk, reset : clock, synchronous active-high reset
//   load       : load load_val this cycle (takes priority over decrement)
//   load_val   : latency to load
//   is_one     : counter currently holds 1 (final busy cycle)
module md_lat_cnt #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             is_one
);

    logic [CNT_W-1:0] cnt;

    // Decrement saturates at zero so the counter can never wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign is_one = (cnt == CNT_W'(1));

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer and HI/LO hazard controller.
//   clk, reset : clock, synchronous active-high reset
//   bus        : md_ctrl_if.slave
//       in : e_valid, e_md_op, flush, d_hilo_use
//       out: start, start_op, mt_we, mt_hi (combinational)
//            busy, done, proto_err (from registered state), stall
module md_ctrl
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES,
    parameter int unsigned CNT_W       = MD_CNT_W
) (
    input logic      clk,
    input logic      reset,
    md_ctrl_if.slave bus
);

    md_state_t                state_q;
    md_state_t                state_d;
    md_op_t                   op;
    logic                     live;
    logic                     start;
    logic [MD_START_OP_W-1:0] start_op;
    logic                     mt_we;
    logic                     mt_hi;
    logic                     cnt_load;
    logic [CNT_W-1:0]         cnt_val;
    logic                     cnt_is_one;
    logic                     proto_set;
    logic                     proto_err_q;
    logic                     busy;

    assign op   = md_op_t'(bus.e_md_op);
    // E-stage slot is ignored while reset is asserted
    assign live = bus.e_valid & ~reset;

    md_lat_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .is_one   (cnt_is_one)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sticky protocol-violation flag
    always_ff @(posedge clk) begin
        if (reset) begin
            proto_err_q <= 1'b0;
        end else if (proto_set) begin
            proto_err_q <= 1'b1;
        end
    end

    // Next state and combinational strobes
    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        start_op  = '0;
        mt_we     = 1'b0;
        mt_hi     = 1'b0;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        proto_set = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // flush cancels the E-stage op outright
                if (live && !bus.flush) begin
                    if (is_md_op(op)) begin
                        start    = 1'b1;
                        start_op = MD_START_OP_W'(bus.e_md_op - MD_OP_W'(1));
                        cnt_load = 1'b1;
                        if (op == MD_MULT || op == MD_MULTU) begin
                            cnt_val = CNT_W'(MULT_CYCLES);
                            state_d = ST_RUN_MUL;
                        end else begin
                            cnt_val = CNT_W'(DIV_CYCLES);
                            state_d = ST_RUN_DIV;
                        end
                    end else if (is_mt_op(op)) begin
                        mt_we = 1'b1;
                        mt_hi = (op == MD_MTHI);
                    end
                end
            end
            ST_RUN_MUL, ST_RUN_DIV: begin
                // In-flight op was committed before the exception point,
                // so flush does not abort it
                if (cnt_is_one) begin
                    state_d = ST_IDLE;
                end
                if (live && (is_md_op(op) || is_mt_op(op))) begin
                    proto_set = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

    assign bus.start     = start;
    assign bus.start_op  = start_op;
    assign bus.mt_we     = mt_we;
    assign bus.mt_hi     = mt_hi;
    assign bus.busy      = busy;
    assign bus.done      = busy & cnt_is_one;
    assign bus.stall     = bus.d_hilo_use & (start | busy);
    assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Testbench for md_ctrl: directed scenarios plus a randomized run checked
// against a cycle-count reference model.
module tb_md_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    // Reference model: cycles of busy still remaining, sticky error flag
    int   rem  = 0;
    bit   perr = 0;

    md_ctrl_if bus ();

    md_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic bit m_start();
        return !reset && rem == 0 && bus.e_valid && bus.e_md_op inside {[3'd1:3'd4]} && !bus.flush;
    endfunction

    function automatic bit m_mt_we();
        return !reset && rem == 0 && bus.e_valid && bus.e_md_op inside {3'd5, 3'd6} && !bus.flush;
    endfunction

    function automatic logic [8:0] m_outputs();
        logic [1:0] sop;
        sop = m_start() ? 2'(bus.e_md_op - 3'd1) : 2'd0;
        return {m_start(), sop, m_mt_we(), m_mt_we() && bus.e_md_op == 3'd5,
                rem > 0, rem == 1, bus.d_hilo_use && (m_start() || rem > 0), perr};
    endfunction

    task automatic drive(input bit v, input int op, input bit fl, input bit use_, input bit rst);
        bus.e_valid    = v;
        bus.e_md_op    = 3'(op);
        bus.flush      = fl;
        bus.d_hilo_use = use_;
        reset          = rst;
        #1;
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge
    task automatic tick();
        int n;
        bit p;
        n = rem;
        p = perr;
        if (reset) begin
            n = 0;
            p = 0;
        end else begin
            if (m_start()) n = (bus.e_md_op <= 3'd2) ? 5 : 10;
            else if (rem > 0) n = rem - 1;
            if (rem > 0 && bus.e_valid && bus.e_md_op inside {[3'd1:3'd6]}) p = 1;
        end
        @(posedge clk);
        rem  = n;
        perr = p;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 0, 0, 1);
            checks++;
            if (bus.start !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: start=%b busy=%b expected 0 0", bus.start, bus.busy);
            end
            tick();
        end
        checks++;
        if (bus.done !== 1'b0 || bus.proto_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: done=%b proto_err=%b expected 0 0", bus.done, bus.proto_err);
        end
        drive(1, 1, 0, 0, 0);
        checks++;
        if (bus.start !== 1'b1 || bus.start_op !== 2'd0) begin
            errors++;
            $display("FAIL reset_release: start=%b start_op=%0d expected 1 0", bus.start, bus.start_op);
        end
        tick();
        drive(0, 0, 0, 0, 0);
        repeat (6) tick();
    endtask

    task automatic test_mult_timing();
        drive(1, 1, 0, 1, 0);
        checks++;
        if (bus.start !== 1'b1 || bus.stall !== 1'b1 || bus.start_op !== 2'd0) begin
            errors++;
            $display("FAIL mult_start: start=%b stall=%b op=%0d expected 1 1 0", bus.start, bus.stall, bus.start_op);
        end
        tick();
        for (int i = 1; i <= 5; i++) begin
            drive(0, 0, 0, 1, 0);
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== (i == 5) || bus.stall !== 1'b1) begin
                errors++;
                $display("FAIL mult_run[%0d]: busy=%b done=%b stall=%b expected 1 %b 1", i, bus.busy, bus.done, bus.stall, i == 5);
            end
            tick();
        end
        drive(0, 0, 0, 1, 0);
        checks++;
        if (bus.busy !== 1'b0 || bus.stall !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL mult_end: busy=%b stall=%b done=%b expected 0 0 0", bus.busy, bus.stall, bus.done);
        end
        tick();
    endtask

    task automatic test_div_flush();
        drive(1, 4, 0, 0, 0);
        checks++;
        if (bus.start !== 1'b1 || bus.start_op !== 2'd3) begin
            errors++;
            $display("FAIL divu_start: start=%b start_op=%0d expected 1 3", bus.start, bus.start_op);
        end
        tick();
        for (int i = 1; i <= 10; i++) begin
            drive(0, 0, i == 5, 0, 0);
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== (i == 10)) begin
                errors++;
                $display("FAIL divu_run[%0d]: busy=%b done=%b expected 1 %b", i, bus.busy, bus.done, i == 10);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL divu_end: busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_flush_start();
        drive(1, 3, 1, 1, 0);
        checks++;
        if (bus.start !== 1'b0 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_div: start=%b stall=%b expected 0 0", bus.start, bus.stall);
        end
        tick();
        drive(1, 6, 1, 0, 0);
        checks++;
        if (bus.busy !== 1'b0 || bus.mt_we !== 1'b0) begin
            errors++;
            $display("FAIL flush_mtlo: busy=%b mt_we=%b expected 0 0", bus.busy, bus.mt_we);
        end
        tick();
    endtask

    task automatic test_mt_and_proto();
        drive(1, 5, 0, 0, 0);
        checks++;
        if (bus.mt_we !== 1'b1 || bus.mt_hi !== 1'b1 || bus.busy !== 1'b0 || bus.start !== 1'b0) begin
            errors++;
            $display("FAIL mthi: mt_we=%b mt_hi=%b busy=%b start=%b expected 1 1 0 0", bus.mt_we, bus.mt_hi, bus.busy, bus.start);
        end
        tick();
        drive(1, 6, 0, 0, 0);
        checks++;
        if (bus.mt_we !== 1'b1 || bus.mt_hi !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mtlo: mt_we=%b mt_hi=%b busy=%b expected 1 0 0", bus.mt_we, bus.mt_hi, bus.busy);
        end
        tick();
        drive(1, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        repeat (2) tick();
        drive(1, 1, 0, 0, 0);
        checks++;
        if (bus.start !== 1'b0 || bus.proto_err !== 1'b0) begin
            errors++;
            $display("FAIL proto_inject: start=%b proto_err=%b expected 0 0", bus.start, bus.proto_err);
        end
        tick();
        drive(0, 0, 0, 0, 0);
        repeat (3) tick();
        checks++;
        if (bus.proto_err !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL proto_sticky: proto_err=%b busy=%b expected 1 0", bus.proto_err, bus.busy);
        end
        drive(0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0);
        checks++;
        if (bus.proto_err !== 1'b0) begin
            errors++;
            $display("FAIL proto_clear: proto_err=%b expected 0", bus.proto_err);
        end
    endtask

    task automatic test_reset_mid_op();
        drive(1, 3, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        repeat (3) tick();
        drive(0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
        tick();
        drive(1, 1, 0, 0, 0);
        checks++;
        if (bus.start !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_restart: start=%b expected 1", bus.start);
        end
        tick();
        for (int i = 1; i <= 6; i++) begin
            drive(0, 0, 0, 0, 0);
            checks++;
            if (bus.busy !== (i <= 5) || bus.done !== (i == 5)) begin
                errors++;
                $display("FAIL reset_mid_seq[%0d]: busy=%b done=%b expected %b %b", i, bus.busy, bus.done, i <= 5, i == 5);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [8:0] obs;
        logic [8:0] exp;
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 49) == 0);
            obs = {bus.start, bus.start_op, bus.mt_we, bus.mt_hi, bus.busy, bus.done, bus.stall, bus.proto_err};
            exp = m_outputs();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random[%0d]: {start,op,mt_we,mt_hi,busy,done,stall,perr}=%b expected %b", c, obs, exp);
            end
            tick();
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 1);
        test_reset();
        test_mult_timing();
        test_div_flush();
        test_flush_start();
        test_mt_and_proto();
        test_reset_mid_op();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
